// File: rtl/bus_arbiter_pkg.sv
// Shared bus package: arbiter state encodings, bus constants,
// latched command bundle and the VGA window decode helper.
package bus_arbiter_pkg;

    localparam int BUS_AW = 32;
    localparam int BUS_DW = 32;

    localparam logic [31:0] VGA_BASE_DEF  = 32'h0010_0000;
    localparam logic [31:0] VGA_LIMIT_DEF = 32'h0020_0000;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_ACK = 2'd2,
        DONE     = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic              we;
        logic [BUS_AW-1:0] addr;
        logic [BUS_DW-1:0] wdata;
    } bus_cmd_t;

    function automatic logic in_vga(
        input logic [31:0] addr,
        input logic [31:0] base,
        input logic [31:0] limit
    );
        return (addr >= base) && (addr < limit);
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Round-robin picker: scans requests starting at ptr with wrap,
// returns a one-hot grant for the first requester found (or zero).
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int PW    = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] gnt
);

    // Priority walk from ptr; first active request wins
    always_comb begin
        gnt = '0;
        for (int k = 0; k < N_REQ; k++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (gnt == '0 && req[i]
                    && i == (int'(ptr) + k) % N_REQ) begin
                    gnt[i] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with VGA/RAM decode.
// Optional ack watchdog built in with `define BUS_TIMEOUT_EN.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int          N_REQ     = 4,
    parameter logic [31:0] VGA_BASE  = VGA_BASE_DEF,
    parameter logic [31:0] VGA_LIMIT = VGA_LIMIT_DEF,
    parameter int          TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_REQ-1:0]  req,
    input  logic [N_REQ*32-1:0] req_addr,
    input  logic [N_REQ*32-1:0] req_wdata,
    input  logic [N_REQ-1:0]  req_we,
    output logic [N_REQ-1:0]  gnt,
    output logic [N_REQ-1:0]  done,
    output logic [31:0]       rdata,
    output logic              err,
    output logic              bus_valid,
    output logic              bus_we,
    output logic [31:0]       bus_addr,
    output logic [31:0]       bus_wdata,
    output logic              vga_sel,
    output logic              ram_sel,
    input  logic              bus_ack,
    input  logic [31:0]       bus_rdata
);

    localparam int PW = $clog2(N_REQ);

    arb_state_t       r_state;
    arb_state_t       w_next;
    logic [N_REQ-1:0] r_owner;
    logic [N_REQ-1:0] w_pick;
    logic [PW-1:0]    r_ptr;
    logic [PW-1:0]    w_nptr;
    bus_cmd_t         r_cmd;
    bus_cmd_t         w_cmd;
    logic [31:0]      r_rdata;
    logic             w_take;
    logic             w_busy;
    logic             w_vga;
    logic             w_tmo;

    rr_pick #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_pick (
        .req (req),
        .ptr (r_ptr),
        .gnt (w_pick)
    );

    assign w_take = (r_state == IDLE) && (req != '0);
    assign w_vga  = in_vga(r_cmd.addr, VGA_BASE, VGA_LIMIT);

    // Select the winner's command and the pointer just past it
    always_comb begin
        w_cmd  = '0;
        w_nptr = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_pick[i]) begin
                w_cmd.we    = req_we[i];
                w_cmd.addr  = req_addr[i*32 +: 32];
                w_cmd.wdata = req_wdata[i*32 +: 32];
                w_nptr      = PW'((i + 1) % N_REQ);
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    // Next state and per-state outputs
    always_comb begin
        w_next    = r_state;
        bus_valid = 1'b0;
        w_busy    = 1'b0;
        gnt       = '0;
        done      = '0;
        unique case (r_state)
            IDLE: begin
                if (req != '0) w_next = ISSUE;
            end
            ISSUE: begin
                bus_valid = 1'b1;
                w_busy    = 1'b1;
                gnt       = r_owner;
                w_next    = bus_ack ? DONE : WAIT_ACK;
            end
            WAIT_ACK: begin
                w_busy = 1'b1;
                gnt    = r_owner;
                if (bus_ack || w_tmo) w_next = DONE;
            end
            DONE: begin
                done   = r_owner;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Latch owner, command and next priority on grant
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owner <= '0;
            r_ptr   <= '0;
            r_cmd   <= '0;
        end else if (w_take) begin
            r_owner <= w_pick;
            r_ptr   <= w_nptr;
            r_cmd   <= w_cmd;
        end
    end

    // Capture read data on device ack
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_rdata <= '0;
        else if (w_busy && bus_ack && !r_cmd.we) r_rdata <= bus_rdata;
    end

    assign vga_sel   = w_busy & w_vga;
    assign ram_sel   = w_busy & ~w_vga;
    assign bus_we    = r_cmd.we;
    assign bus_addr  = r_cmd.addr;
    assign bus_wdata = r_cmd.wdata;
    assign rdata     = r_rdata;

`ifdef BUS_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_cnt;
    logic          r_err;
    logic          w_fin;

    assign w_fin = (w_next == DONE) && (r_state != DONE);
    assign w_tmo = (r_cnt == CW'(TIMEOUT - 1));
    assign err   = r_err;

    // Count unanswered WAIT_ACK cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_cnt <= '0;
        else if (r_state == WAIT_ACK && !bus_ack) r_cnt <= r_cnt + 1'b1;
        else r_cnt <= '0;
    end

    // Flag completions caused by the watchdog
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_err <= 1'b0;
        else if (w_fin) r_err <= (r_state == WAIT_ACK) && !bus_ack;
    end
`else
    // TIMEOUT only matters when the watchdog is built in
    localparam int unused_timeout = TIMEOUT;

    assign w_tmo = 1'b0;
    assign err   = 1'b0;
`endif

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, SHALL set the number of requesters (2..8).
REQ-002 Parameter VGA_BASE, default 32'h0010_0000, SHALL set the inclusive lower bound of the VGA window.
REQ-003 Parameter VGA_LIMIT, default 32'h0020_0000, SHALL set the exclusive upper bound of the VGA window.
REQ-004 Parameter TIMEOUT, default 255, SHALL set the watchdog limit in cycles (used only under REQ-027).
REQ-005 clk  in  1  SHALL be the single clock; all state changes on posedge.
REQ-006 rst  in  1  SHALL be the asynchronous, active-low reset.
REQ-007 req  in  N_REQ  SHALL carry per-requester transfer requests, held high until done.
REQ-008 req_addr / req_wdata  in  N_REQ*32 each  SHALL carry packed per-requester address and write data.
REQ-009 req_we  in  N_REQ  SHALL select write (1) or read (0) per requester.
REQ-010 gnt  out  N_REQ  SHALL be one-hot (or zero), identifying the current bus owner.
REQ-011 done  out  N_REQ  SHALL pulse high one cycle to the owner on completion.
REQ-012 rdata  out  32  SHALL hold read data captured at completion; err  out  1  SHALL flag an aborted transfer, valid with done.
REQ-013 bus_valid / bus_we  out  1 each; bus_addr / bus_wdata  out  32 each  SHALL form the device-side command.
REQ-014 vga_sel / ram_sel  out  1 each  SHALL be the decoded device selects, mutually exclusive.
REQ-015 bus_ack  in  1; bus_rdata  in  32  SHALL be the device completion strobe and read data.

Function
REQ-016 FSM states SHALL be IDLE, ISSUE, WAIT_ACK, DONE.
REQ-017 IDLE: if any req bit set, SHALL grant round-robin starting at the index after the last owner, latch its addr/data/we, and go to ISSUE next cycle.
REQ-018 ISSUE: SHALL assert bus_valid with latched command and decoded select for exactly one cycle, then go to WAIT_ACK.
REQ-019 Decode: VGA_BASE <= addr < VGA_LIMIT SHALL give vga_sel=1, otherwise ram_sel=1; selects held from ISSUE through WAIT_ACK.
REQ-020 WAIT_ACK: bus_valid SHALL be 0; on bus_ack, SHALL capture bus_rdata (reads only) and go to DONE.
REQ-021 bus_ack arriving in ISSUE SHALL be accepted as completion (ISSUE -> DONE directly).
REQ-022 DONE: SHALL pulse done[owner], drop gnt and selects, return to IDLE; new grant no earlier than the following cycle.
REQ-023 Minimum latency req -> done SHALL be 3 cycles with same-cycle ack in ISSUE.
REQ-024 Requests dropped while granted SHALL NOT abort the transfer; done still pulses.
REQ-025 Round-robin pointer SHALL wrap from N_REQ-1 to 0; a sole requester SHALL be regranted back-to-back.

Reset
REQ-026 rst low SHALL force IDLE, gnt=0, done=0, bus_valid=0, bus_we=0, vga_sel=0, ram_sel=0, bus_addr=0, bus_wdata=0, rdata=0, err=0, priority pointer=0, immediately and mid-transfer; no done issued for an interrupted transfer.

Configuration
REQ-027 With BUS_TIMEOUT_EN defined, a counter SHALL run in WAIT_ACK and, on reaching TIMEOUT without bus_ack, SHALL go to DONE with err=1 and rdata unchanged; without it, err SHALL be constant 0 and WAIT_ACK SHALL wait indefinitely.

Structure
REQ-028 State encodings and default VGA_BASE/VGA_LIMIT constants SHALL live in the shared bus package alongside control-pin definitions.
REQ-029 Round-robin grant selection SHALL be a sub-module rr_pick (req, last pointer -> one-hot grant).

Verification
REQ-030 req=0001 write addr 0x0010_0040, ack one cycle after ISSUE -> vga_sel=1, bus_we=1, done[0] at cycle 4, err=0.
REQ-031 req=1111 held, immediate acks -> grants in order 0,1,2,3,0 with no idle gap beyond DONE.
REQ-032 req=0010 read addr 0x0000_1000, bus_rdata=0xDEADBEEF on ack -> ram_sel=1, rdata=0xDEADBEEF with done[1].
REQ-033 Address 0x0020_0000 -> ram_sel=1 (limit exclusive); 0x000F_FFFF -> ram_sel=1; 0x0010_0000 -> vga_sel=1.
REQ-034 rst low during WAIT_ACK -> all outputs zero same cycle, no done pulse after release.
REQ-035 BUS_TIMEOUT_EN, TIMEOUT=8, no ack -> done with err=1 after 8 WAIT_ACK cycles, then next requester granted.
